// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path.
//   - Baud divisors for a 50 MHz system clock (clock cycles per bit).
//   - Encodings for the transmit-feeder sequencer states.
// No ports; imported by the transmit feeder.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;

  // Clock cycles per bit, rounded to nearest, at CLK_HZ
  localparam int unsigned B115200 = 434;
  localparam int unsigned B57600  = 868;
  localparam int unsigned B38400  = 1302;
  localparam int unsigned B19200  = 2604;
  localparam int unsigned B9600   = 5208;
  localparam int unsigned B4800   = 10417;
  localparam int unsigned B2400   = 20833;
  localparam int unsigned B1200   = 41667;
  localparam int unsigned B600    = 83333;
  localparam int unsigned B300    = 166667;

  // Sequencer states; the encoding is wider than needed so that stray
  // values exist and are explicitly steered back to IDLE
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO with a separate occupancy counter.
// Ports:
//   clk      in   system clock
//   rstn     in   synchronous active-low reset (flushes pointers and level)
//   i_push   in   write i_din this cycle
//   i_pop    in   discard the head entry this cycle (ignored when empty)
//   i_din    in   WIDTH  data to write
//   o_dout   out  WIDTH  head entry, shown combinationally from memory
//   o_full   out  level == 2**DEPTH_LOG2
//   o_empty  out  level == 0
//   o_level  out  DEPTH_LOG2+1  current occupancy
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_MAX  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  // full/empty come straight from the level register, so they carry no
  // combinational path from the push/pop inputs
  assign o_full    = (r_level == LVL_MAX);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally at DEPTH; level is unchanged on push+pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - LVL_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte buffer in front of the serial transmitter. Producers write bytes at
// core speed into a FIFO; a sequencer hands them to the transmitter one at a
// time over its start/data/ready handshake.
// Ports:
//   clk         in   system clock (50 MHz)
//   rstn        in   synchronous active-low reset
//   i_wr_en     in   push i_wr_data this cycle
//   i_wr_data   in   8  byte to queue
//   o_full      out  FIFO holds 2**DEPTH_LOG2 bytes
//   o_empty     out  FIFO holds 0 bytes
//   o_level     out  DEPTH_LOG2+1  byte count
//   o_overflow  out  sticky: a write was dropped because the FIFO was full
//   o_tx_err    out  sticky: transmitter never went busy after a start
//   o_tx_start  out  registered one-cycle start pulse to the transmitter
//   o_tx_data   out  8  registered byte, stable until the next pop
//   i_tx_ready  in   transmitter idle (1) / busy (0)
// BUSY_TIMEOUT must lie in 3..7 (3-bit timeout counter).
// ---------------------------------------------------------------------------
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_tx_err,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready
);

  localparam logic [2:0] CNT_LAST = 3'(BUSY_TIMEOUT - 1);
  localparam logic [2:0] CNT_ONE  = 3'd1;

  logic [2:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_overflow;
  logic        r_tx_err;

  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_head;
  logic        w_pop;
  logic        w_drop;
  logic        w_timeout;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (i_wr_en),
    .i_pop   (w_pop),
    .i_din   (i_wr_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Pop only from IDLE with the transmitter idle, so a start pulse is never
  // issued while ready is low
  assign w_pop     = (r_state == IDLE) && !w_empty && i_tx_ready;

  // A full FIFO still takes the write when the head leaves in the same cycle
  assign w_drop    = i_wr_en && w_full && !w_pop;

  // Counter started at 0 on WAIT_BUSY entry, so the last allowed value is
  // BUSY_TIMEOUT-1 and the flag lands BUSY_TIMEOUT cycles after entry
  assign w_timeout = (r_state == WAIT_BUSY) && i_tx_ready && (r_cnt == CNT_LAST);

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;
  assign o_tx_err   = r_tx_err;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

  // Sequencer: data and start are registered together because the
  // transmitter latches data on the cycle start is high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_tx_start <= 1'b0;
          r_cnt      <= '0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i_tx_ready) begin
            r_state <= WAIT_DONE;
          end else if (w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_timeout) begin
        r_tx_err <= 1'b1;
      end
    end
  end

endmodule
